console_vram_ctrl: RTL and testbench

- Owns the single-port text VRAM (40x30 cells, 11-bit address, 8-bit character code) and shares it between the display read path and a character-stream writer.
- The display read path always wins. Writer accesses happen only in cycles where the display does not request.
- Implements the console's terminal semantics: cursor, CR/LF/BS, line wrap, wrap to top with line clear, full-screen clear.
- Sits between the dynamic console stage (read address source), the VRAM, and a UART or CPU character source.

---
 rtl/console_vram_ctrl_pkg.sv | 25 ++
 rtl/console_cursor.sv | 67 ++++++
 rtl/console_vram_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_console_vram_ctrl.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/console_vram_ctrl_pkg.sv
// Shared console constants: screen geometry, control codes and FSM state encoding.
package console_vram_ctrl_pkg;

  localparam int SCREEN_W = 40;
  localparam int SCREEN_H = 30;
  localparam int ADDR_W   = 11;
  localparam int COL_W    = 6;
  localparam int ROW_W    = 5;

  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_PR_LO = 8'h20;
  localparam logic [7:0] CH_PR_HI = 8'h7E;
  localparam logic [7:0] CH_FILL  = 8'h20;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXEC,
    S_WRITE,
    S_CLRLINE,
    S_CLRALL
  } state_t;

endpackage

// File: rtl/console_cursor.sv
// Cursor position registers with terminal controls and a shift-add cell address.
module console_cursor
  import console_vram_ctrl_pkg::*;
#(
  parameter int screenW = SCREEN_W,
  parameter int screenH = SCREEN_H
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              adv,
  input  logic              cr,
  input  logic              lf,
  input  logic              bs,
  input  logic              home,
  output logic [COL_W-1:0]  cursor_x,
  output logic [ROW_W-1:0]  cursor_y,
  output logic              last_col,
  output logic              wrap,
  output logic [ADDR_W-1:0] row_base,
  output logic [ADDR_W-1:0] cell_addr
);

  localparam logic [ADDR_W-1:0] W_BITS = ADDR_W'(screenW);

  // Constant multiply by the row width as a sum of shifted copies of the row.
  function automatic logic [ADDR_W-1:0] row_offset(input logic [ROW_W-1:0] y);
    logic [ADDR_W-1:0] acc;
    acc = '0;
    for (int b = 0; b < ADDR_W; b++) begin
      if (W_BITS[b]) acc = acc + (ADDR_W'(y) << b);
    end
    return acc;
  endfunction

  logic [ROW_W-1:0] next_row;

  assign last_col  = (cursor_x == COL_W'(screenW - 1));
  assign wrap      = (cursor_y == ROW_W'(screenH - 1));
  assign next_row  = wrap ? '0 : cursor_y + ROW_W'(1);
  assign row_base  = row_offset(cursor_y);
  assign cell_addr = row_base + ADDR_W'(cursor_x);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cursor_x <= '0;
      cursor_y <= '0;
    end else if (home) begin
      cursor_x <= '0;
      cursor_y <= '0;
    end else if (adv) begin
      if (last_col) begin
        cursor_x <= '0;
        cursor_y <= next_row;
      end else begin
        cursor_x <= cursor_x + COL_W'(1);
      end
    end else if (lf) begin
      cursor_x <= '0;
      cursor_y <= next_row;
    end else if (cr) begin
      cursor_x <= '0;
    end else if (bs && cursor_x != '0) begin
      cursor_x <= cursor_x - COL_W'(1);
    end
  end

endmodule

// File: rtl/console_vram_ctrl.sv
// Text VRAM arbiter and terminal FSM: display reads always win, the character writer fills free cycles.
module console_vram_ctrl
  import console_vram_ctrl_pkg::*;
#(
  parameter int         screenW   = SCREEN_W,
  parameter int         screenH   = SCREEN_H,
  parameter logic [7:0] fill_char = CH_FILL
) (
  input  logic              px_clk,
  input  logic              rst_n,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  input  logic [7:0]        char_i,
  input  logic              char_valid,
  output logic              char_ready,
  input  logic              clear_req,
  output logic [ADDR_W-1:0] vram_addr,
  output logic              vram_we,
  output logic [7:0]        vram_din,
  output logic [COL_W-1:0]  cursor_x,
  output logic [ROW_W-1:0]  cursor_y,
  output logic              busy
);

  state_t            state, state_nxt;
  logic [7:0]        hold, hold_nxt;
  logic              bs_wr, bs_wr_nxt;
  logic [ADDR_W-1:0] cnt, cnt_nxt;
  logic              pend;
  logic              clr_done;
  logic              free;

  logic              adv, cr, lf, bs, home;
  logic              last_col, wrap;
  logic [ADDR_W-1:0] row_base, cell_addr;

  logic              write_need;
  logic [ADDR_W-1:0] waddr;
  logic [7:0]        wdata;

  console_cursor #(
    .screenW (screenW),
    .screenH (screenH)
  ) u_cursor (
    .clk       (px_clk),
    .rst_n     (rst_n),
    .adv       (adv),
    .cr        (cr),
    .lf        (lf),
    .bs        (bs),
    .home      (home),
    .cursor_x  (cursor_x),
    .cursor_y  (cursor_y),
    .last_col  (last_col),
    .wrap      (wrap),
    .row_base  (row_base),
    .cell_addr (cell_addr)
  );

  assign free       = !disp_req;
  assign char_ready = (state == S_IDLE) && !pend;
  assign busy       = (state != S_IDLE) || pend;

  always_comb begin
    state_nxt  = state;
    hold_nxt   = hold;
    bs_wr_nxt  = bs_wr;
    cnt_nxt    = cnt;
    clr_done   = 1'b0;
    adv        = 1'b0;
    cr         = 1'b0;
    lf         = 1'b0;
    bs         = 1'b0;
    home       = 1'b0;
    write_need = 1'b0;
    waddr      = cell_addr;
    wdata      = hold;
    case (state)
      S_IDLE: begin
        if (pend) begin
          state_nxt = S_CLRALL;
        end else if (char_valid) begin
          hold_nxt  = char_i;
          state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        if (hold >= CH_PR_LO && hold <= CH_PR_HI) begin
          bs_wr_nxt = 1'b0;
          state_nxt = S_WRITE;
        end else if (hold == CH_CR) begin
          cr        = 1'b1;
          state_nxt = S_IDLE;
        end else if (hold == CH_LF) begin
          lf        = 1'b1;
          state_nxt = wrap ? S_CLRLINE : S_IDLE;
        end else if (hold == CH_BS && cursor_x != '0) begin
          // Backspace erases the cell it moves onto and does not re-advance.
          bs        = 1'b1;
          hold_nxt  = fill_char;
          bs_wr_nxt = 1'b1;
          state_nxt = S_WRITE;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_WRITE: begin
        write_need = 1'b1;
        if (free) begin
          if (bs_wr) begin
            state_nxt = S_IDLE;
          end else begin
            adv       = 1'b1;
            state_nxt = (last_col && wrap) ? S_CLRLINE : S_IDLE;
          end
        end
      end
      S_CLRLINE: begin
        write_need = 1'b1;
        waddr      = row_base + cnt;
        wdata      = fill_char;
        if (free) begin
          if (cnt == ADDR_W'(screenW - 1)) begin
            cnt_nxt   = '0;
            state_nxt = S_IDLE;
          end else begin
            cnt_nxt = cnt + ADDR_W'(1);
          end
        end
      end
      S_CLRALL: begin
        write_need = 1'b1;
        waddr      = cnt;
        wdata      = fill_char;
        if (free) begin
          if (cnt == ADDR_W'(screenW * screenH - 1)) begin
            cnt_nxt   = '0;
            home      = 1'b1;
            clr_done  = 1'b1;
            state_nxt = S_IDLE;
          end else begin
            cnt_nxt = cnt + ADDR_W'(1);
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge px_clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      bs_wr     <= 1'b0;
      cnt       <= '0;
      pend      <= 1'b0;
      vram_addr <= '0;
      vram_we   <= 1'b0;
      vram_din  <= '0;
    end else begin
      state <= state_nxt;
      bs_wr <= bs_wr_nxt;
      cnt   <= cnt_nxt;
      // A new pulse on the completing cycle stays pending as a fresh request.
      pend  <= clear_req | (pend & ~clr_done);
      if (disp_req) begin
        vram_addr <= disp_addr;
        vram_we   <= 1'b0;
      end else if (write_need) begin
        vram_addr <= waddr;
        vram_din  <= wdata;
        vram_we   <= 1'b1;
      end else begin
        vram_we <= 1'b0;
      end
    end
  end

  always_ff @(posedge px_clk) begin
    hold <= hold_nxt;
  end

endmodule

// File: tb/tb_console_vram_ctrl.sv
// Directed bench for console_vram_ctrl: arbitration, terminal codes, wraps and clears.
module tb_console_vram_ctrl;

  logic        px_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        disp_req = 1'b0;
  logic [10:0] disp_addr = '0;
  logic [7:0]  char_i = '0;
  logic        char_valid = 1'b0;
  logic        clear_req = 1'b0;
  logic        char_ready;
  logic [10:0] vram_addr;
  logic        vram_we;
  logic [7:0]  vram_din;
  logic [5:0]  cursor_x;
  logic [4:0]  cursor_y;
  logic        busy;

  int checks = 0;
  int errors = 0;
  logic [18:0] wq[$];

  console_vram_ctrl dut (
    .px_clk     (px_clk),
    .rst_n      (rst_n),
    .disp_req   (disp_req),
    .disp_addr  (disp_addr),
    .char_i     (char_i),
    .char_valid (char_valid),
    .char_ready (char_ready),
    .clear_req  (clear_req),
    .vram_addr  (vram_addr),
    .vram_we    (vram_we),
    .vram_din   (vram_din),
    .cursor_x   (cursor_x),
    .cursor_y   (cursor_y),
    .busy       (busy)
  );

  always #5 px_clk = ~px_clk;

  always @(negedge px_clk) begin
    if (vram_we) wq.push_back({vram_addr, vram_din});
  end

  task automatic step();
    @(posedge px_clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    disp_req   = 1'b0;
    char_valid = 1'b0;
    clear_req  = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic send(input logic [7:0] c);
    int n;
    n = 0;
    while (!char_ready && n < 3000) begin
      step();
      n++;
    end
    chk("ready_wait", char_ready, 1);
    char_i     = c;
    char_valid = 1'b1;
    step();
    char_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 3000) begin
      step();
      n++;
    end
    chk("idle_wait", busy, 0);
    step();
    step();
  endtask

  task automatic put(input logic [7:0] c);
    send(c);
    wait_idle();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    int n;

    // Reset values and a plain display read.
    do_reset();
    chk("rst_addr", vram_addr, 0);
    chk("rst_we", vram_we, 0);
    chk("rst_din", vram_din, 0);
    chk("rst_cx", cursor_x, 0);
    chk("rst_cy", cursor_y, 0);
    chk("rst_busy", busy, 0);
    disp_req  = 1'b1;
    disp_addr = 11'd123;
    step();
    chk("rd_addr", vram_addr, 123);
    chk("rd_we", vram_we, 0);
    chk("rd_din", vram_din, 0);
    chk("rd_cursor", {cursor_y, cursor_x}, 0);
    chk("rd_busy", busy, 0);
    disp_req = 1'b0;
    step();

    // Single printable character.
    wq.delete();
    put(8'h41);
    chk("a_count", wq.size(), 1);
    chk("a_write", wq[0], {11'd0, 8'h41});
    chk("a_cx", cursor_x, 1);
    chk("a_cy", cursor_y, 0);
    chk("a_ready", char_ready, 1);

    // Writer starved by display reads for 20+ cycles.
    wq.delete();
    disp_req  = 1'b1;
    disp_addr = 11'd200;
    send(8'h42);
    chk("b_rd0", {vram_we, vram_addr}, {1'b0, 11'd200});
    for (int i = 1; i <= 20; i++) begin
      disp_addr = 11'(200 + i);
      step();
      chk("b_rd", {vram_we, vram_addr}, {1'b0, 11'(200 + i)});
    end
    disp_req = 1'b0;
    step();
    chk("b_we", vram_we, 1);
    chk("b_addr", vram_addr, 1);
    chk("b_din", vram_din, 8'h42);
    wait_idle();
    chk("b_count", wq.size(), 1);
    chk("b_cursor", {cursor_y, cursor_x}, {5'd0, 6'd2});

    // Bottom-right cell wraps to the top and clears row 0.
    do_reset();
    for (int i = 0; i < 29; i++) put(8'h0A);
    chk("lf_cy", cursor_y, 29);
    for (int i = 0; i < 39; i++) put(8'h61);
    chk("fill_cx", cursor_x, 39);
    wq.delete();
    put(8'h5A);
    chk("z_count", wq.size(), 41);
    chk("z_write", wq[0], {11'd1199, 8'h5A});
    bad = 0;
    for (int i = 0; i < 40 && i + 1 < wq.size(); i++) begin
      if (wq[i + 1] !== {11'(i), 8'h20}) bad++;
    end
    chk("z_clrline", bad, 0);
    chk("z_cursor", {cursor_y, cursor_x}, 0);

    // Backspace, CR, LF, ignored control code.
    do_reset();
    for (int i = 0; i < 3; i++) put(8'h0A);
    for (int i = 0; i < 5; i++) put(8'h63);
    chk("pre_bs", {cursor_y, cursor_x}, {5'd3, 6'd5});
    wq.delete();
    put(8'h08);
    chk("bs_count", wq.size(), 1);
    chk("bs_write", wq[0], {11'd124, 8'h20});
    chk("bs_cursor", {cursor_y, cursor_x}, {5'd3, 6'd4});
    for (int i = 0; i < 4; i++) put(8'h08);
    wq.delete();
    put(8'h08);
    chk("bs0_count", wq.size(), 0);
    chk("bs0_cursor", {cursor_y, cursor_x}, {5'd3, 6'd0});
    put(8'h78);
    put(8'h0D);
    chk("cr_cursor", {cursor_y, cursor_x}, {5'd3, 6'd0});
    chk("cr_write", wq[0], {11'd120, 8'h78});
    put(8'h0A);
    chk("lf_cursor", {cursor_y, cursor_x}, {5'd4, 6'd0});
    wq.delete();
    put(8'h07);
    chk("ctl_count", wq.size(), 0);
    chk("ctl_cursor", {cursor_y, cursor_x}, {5'd4, 6'd0});

    // Clear pulse during CLRLINE together with a waiting character.
    do_reset();
    for (int i = 0; i < 29; i++) put(8'h0A);
    wq.delete();
    send(8'h0A);
    step();
    chk("cl_busy", busy, 1);
    clear_req  = 1'b1;
    char_i     = 8'h51;
    char_valid = 1'b1;
    step();
    clear_req = 1'b0;
    bad = 0;
    n = 0;
    while (busy && n < 3000) begin
      if (char_ready) bad++;
      step();
      n++;
    end
    chk("cl_ready_low", bad, 0);
    chk("cl_done", busy, 0);
    chk("cl_cursor", {cursor_y, cursor_x}, 0);
    chk("cl_ready", char_ready, 1);
    step();
    char_valid = 1'b0;
    chk("cl_accept", busy, 1);
    wait_idle();
    chk("cl_count", wq.size(), 1241);
    bad = 0;
    for (int i = 0; i < 40 && i < wq.size(); i++) begin
      if (wq[i] !== {11'(i), 8'h20}) bad++;
    end
    for (int i = 0; i < 1200 && 40 + i < wq.size(); i++) begin
      if (wq[40 + i] !== {11'(i), 8'h20}) bad++;
    end
    chk("cl_seq", bad, 0);
    chk("cl_char", wq[wq.size() - 1], {11'd0, 8'h51});
    chk("cl_end_cursor", {cursor_y, cursor_x}, {5'd0, 6'd1});

    // Starvation, collapsed clear pulses, then reset mid-clear.
    wq.delete();
    disp_req  = 1'b1;
    disp_addr = 11'd5;
    for (int k = 0; k < 3; k++) begin
      clear_req = 1'b1;
      step();
      clear_req = 1'b0;
      repeat (3) step();
    end
    repeat (50) step();
    chk("sv_writes", wq.size(), 0);
    chk("sv_busy", busy, 1);
    chk("sv_ready", char_ready, 0);
    disp_req = 1'b0;
    wait_idle();
    chk("sv_count", wq.size(), 1200);
    chk("sv_last", wq[wq.size() - 1], {11'd1199, 8'h20});
    chk("sv_cursor", {cursor_y, cursor_x}, 0);
    put(8'h41);
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    repeat (100) step();
    chk("mr_busy_pre", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mr_we", vram_we, 0);
    chk("mr_busy", busy, 0);
    chk("mr_cursor", {cursor_y, cursor_x}, 0);
    step();
    rst_n = 1'b1;
    wq.delete();
    repeat (5) step();
    chk("mr_quiet", wq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
